// File: rtl/spsram_ctrl.sv
// ---------------------------------------------------------------------------
// spsram_ctrl
// Request-side controller for one single-port SRAM instance. Accepts one
// read or write request at a time over a valid/ready handshake, drives the
// SRAM pins from registers, waits out the SRAM address/data pipeline and
// returns read data over a valid/ready response channel.
//
// Optional feature (macro SPSRAM_CTRL_PARITY_CHK_EN):
//   defined   : mem_parity is captured and checked against the read data
//               (even parity); mismatches raise o_rsp_parity_err.
//   undefined : no parity capture register, mem_parity ignored,
//               o_rsp_parity_err always 0. Data timing is identical.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready        request handshake
//   i_req_wr, i_req_addr, i_req_wdata  request payload (1 = write)
//   o_rsp_valid/i_rsp_ready        read response handshake
//   o_rsp_rdata, o_rsp_parity_err  response payload
//   o_mem_*                        SRAM pin controls, address and write data
//   i_mem_dout, i_mem_parity       SRAM read data and parity
// ---------------------------------------------------------------------------
module spsram_ctrl #(
  parameter int unsigned MEM_WIDTH   = 16,
  parameter int unsigned ADDR_SIZE   = 10,
  parameter int unsigned WR_HOLD     = 2,
  parameter int unsigned RD_LATENCY  = 4,
  parameter int unsigned PAR_LATENCY = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  // request channel
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wr,
  input  logic [ADDR_SIZE-1:0] i_req_addr,
  input  logic [MEM_WIDTH-1:0] i_req_wdata,
  // response channel
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [MEM_WIDTH-1:0] o_rsp_rdata,
  output logic                 o_rsp_parity_err,
  // SRAM pins
  output logic [MEM_WIDTH-1:0] o_mem_din,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic                 o_mem_wr_en,
  output logic                 o_mem_rd_en,
  output logic                 o_mem_blk_select,
  output logic                 o_mem_addr_en,
  output logic                 o_mem_dout_en,
  input  logic [MEM_WIDTH-1:0] i_mem_dout,
  input  logic                 i_mem_parity
);

  // Counter must reach max(WR_HOLD, RD_LATENCY) without wrapping.
  localparam int unsigned CNT_MAX = (WR_HOLD > RD_LATENCY) ? WR_HOLD : RD_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_par_err;
  logic               w_accept;
  logic               w_wr_done;
  logic               w_rd_done;

  assign w_accept  = i_req_valid && o_req_ready;
  assign w_wr_done = (r_cnt == CNT_W'(WR_HOLD - 1));
  assign w_rd_done = (r_cnt == CNT_W'(RD_LATENCY));

`ifdef SPSRAM_CTRL_PARITY_CHK_EN
  logic r_par;
  logic w_par_hit;
  logic w_par_src;

  // Parity edge may coincide with the data edge, so bypass the register then.
  assign w_par_hit = (r_state == S_READ) && (r_cnt == CNT_W'(PAR_LATENCY));
  assign w_par_src = w_par_hit ? i_mem_parity : r_par;
  assign w_par_err = (^i_mem_dout) ^ w_par_src;

  // Parity capture register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par <= 1'b0;
    end else if (w_par_hit) begin
      r_par <= i_mem_parity;
    end
  end
`else
  logic w_unused_par;

  assign w_par_err    = 1'b0;
  assign w_unused_par = i_mem_parity ^ (PAR_LATENCY > RD_LATENCY);
`endif

  // Controller FSM; every output is a register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      o_req_ready      <= 1'b0;
      o_rsp_valid      <= 1'b0;
      o_rsp_rdata      <= '0;
      o_rsp_parity_err <= 1'b0;
      o_mem_din        <= '0;
      o_mem_addr       <= '0;
      o_mem_wr_en      <= 1'b0;
      o_mem_rd_en      <= 1'b0;
      o_mem_blk_select <= 1'b0;
      o_mem_addr_en    <= 1'b0;
      o_mem_dout_en    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_req_ready <= 1'b1;
          if (w_accept) begin
            // Launch edge: pins take the request values right away.
            o_req_ready      <= 1'b0;
            o_mem_addr       <= i_req_addr;
            o_mem_blk_select <= 1'b1;
            r_cnt            <= '0;
            if (i_req_wr) begin
              o_mem_din   <= i_req_wdata;
              o_mem_wr_en <= 1'b1;
              r_state     <= S_WRITE;
            end else begin
              o_mem_rd_en   <= 1'b1;
              o_mem_addr_en <= 1'b1;
              o_mem_dout_en <= 1'b1;
              r_state       <= S_READ;
            end
          end
        end

        S_WRITE: begin
          if (w_wr_done) begin
            o_mem_wr_en      <= 1'b0;
            o_mem_blk_select <= 1'b0;
            o_req_ready      <= 1'b1;
            r_cnt            <= '0;
            r_state          <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_READ: begin
          if (w_rd_done) begin
            o_mem_rd_en      <= 1'b0;
            o_mem_addr_en    <= 1'b0;
            o_mem_dout_en    <= 1'b0;
            o_mem_blk_select <= 1'b0;
            o_rsp_valid      <= 1'b1;
            o_rsp_rdata      <= i_mem_dout;
            o_rsp_parity_err <= w_par_err;
            r_cnt            <= '0;
            r_state          <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          // Response payload holds until the consumer takes it.
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spsram_ctrl.sv
module tb_spsram_ctrl;

  localparam int unsigned MW   = 16;
  localparam int unsigned AW   = 10;
  localparam int unsigned WRH  = 2;
  localparam int unsigned RDL  = 4;
  localparam int unsigned PARL = 3;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [MW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [MW-1:0] rsp_rdata;
  logic          rsp_parity_err;
  logic [MW-1:0] mem_din;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic          mem_blk_select;
  logic          mem_addr_en;
  logic          mem_dout_en;
  logic [MW-1:0] mem_dout;
  logic          mem_parity;

  spsram_ctrl #(
    .MEM_WIDTH  (MW),
    .ADDR_SIZE  (AW),
    .WR_HOLD    (WRH),
    .RD_LATENCY (RDL),
    .PAR_LATENCY(PARL)
  ) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_wr        (req_wr),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_rdata     (rsp_rdata),
    .o_rsp_parity_err(rsp_parity_err),
    .o_mem_din       (mem_din),
    .o_mem_addr      (mem_addr),
    .o_mem_wr_en     (mem_wr_en),
    .o_mem_rd_en     (mem_rd_en),
    .o_mem_blk_select(mem_blk_select),
    .o_mem_addr_en   (mem_addr_en),
    .o_mem_dout_en   (mem_dout_en),
    .i_mem_dout      (mem_dout),
    .i_mem_parity    (mem_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: write on enable, read through a fixed pipeline.
  logic [MW-1:0] sram  [0:(1<<AW)-1];
  logic [MW-1:0] dpipe [0:RDL-1];
  logic          ppipe [0:PARL-1];
  logic          par_flip = 1'b0;

  always @(posedge clk) begin
    if (mem_blk_select && mem_wr_en) sram[mem_addr] <= mem_din;
    if (mem_blk_select && mem_rd_en) begin
      dpipe[0] <= sram[mem_addr];
      ppipe[0] <= (^sram[mem_addr]) ^ par_flip;
    end else begin
      dpipe[0] <= '0;
      ppipe[0] <= 1'b0;
    end
    for (int i = 1; i < RDL; i++)  dpipe[i] <= dpipe[i-1];
    for (int i = 1; i < PARL; i++) ppipe[i] <= ppipe[i-1];
  end

  assign mem_dout   = dpipe[RDL-1];
  assign mem_parity = ppipe[PARL-1];

  // Scoreboard: expected read responses in issue order.
  typedef struct packed {
    logic [MW-1:0] data;
    logic          perr;
  } exp_t;

  exp_t          sb_q[$];
  logic [MW-1:0] exp_mem [0:(1<<AW)-1];

  int vectors     = 0;
  int miscompares = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and wait (bounded) for its acceptance edge.
  task automatic send_req(input logic wr, input logic [AW-1:0] addr,
                          input logic [MW-1:0] data, output int t_acc);
    int n;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    n = 0;
    while (!req_ready && n < 50) begin
      tick;
      n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    tick;
    t_acc = cyc;
    if (wr) exp_mem[addr] = data;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int bp, input logic flip);
    int   n;
    int   t0;
    exp_t e;
    par_flip = flip;
    e.data = exp_mem[addr];
`ifdef SPSRAM_CTRL_PARITY_CHK_EN
    e.perr = flip;
`else
    e.perr = 1'b0;
`endif
    sb_q.push_back(e);
    send_req(1'b0, addr, '0, t0);
    req_valid = 1'b0;
    check("rd_launch_en", 32'({mem_blk_select, mem_rd_en, mem_addr_en, mem_dout_en, mem_wr_en}), 32'b11110);
    check("rd_launch_addr", 32'(mem_addr), 32'(addr));
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick;
      n++;
    end
    check("rd_latency", 32'(n), 32'(RDL + 1));
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", 32'(rsp_rdata), 32'(sb_q[0].data));
      check("bp_busy", 32'({req_ready, mem_blk_select, mem_rd_en}), 32'd0);
      tick;
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
      check("rsp_parity_err", 32'(rsp_parity_err), 32'(e.perr));
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("rsp_req_ready", 32'(req_ready), 32'd1);
    par_flip = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int t0, t1, t2;
    logic seen;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state.
    repeat (3) tick;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_ctl", 32'({mem_wr_en, mem_rd_en, mem_blk_select, mem_addr_en, mem_dout_en}), 32'd0);
    check("rst_mem_bus", 32'({mem_addr, mem_din}), 32'd0);
    rst_n = 1'b1;
    tick;
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Write 0x1234 @0x005: enable held exactly WR_HOLD cycles.
    send_req(1'b1, 10'h005, 16'h1234, t0);
    req_valid = 1'b0;
    check("wr_ctl", 32'({mem_blk_select, mem_wr_en, mem_rd_en}), 32'b110);
    check("wr_addr", 32'(mem_addr), 32'h005);
    check("wr_din", 32'(mem_din), 32'h1234);
    n = 0;
    while (mem_wr_en && n < 10) begin
      n++;
      tick;
    end
    check("wr_hold_cycles", 32'(n), 32'(WRH));
    check("wr_done_ready", 32'({req_ready, mem_blk_select}), 32'b10);

    // Read back, then again with back-pressure.
    do_read(10'h005, 0, 1'b0);
    do_read(10'h005, 3, 1'b0);

    // Other data patterns.
    send_req(1'b1, 10'h3FF, 16'hFFFF, t0);
    req_valid = 1'b0;
    do_read(10'h3FF, 1, 1'b0);

    // Parity error injection.
    send_req(1'b1, 10'h010, 16'h0001, t0);
    req_valid = 1'b0;
    do_read(10'h010, 0, 1'b1);

    // Reset in the middle of a read: nothing comes out afterwards.
    send_req(1'b0, 10'h005, '0, t0);
    req_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", 32'({mem_rd_en, mem_blk_select, mem_addr_en, mem_dout_en}), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", 32'(seen), 32'd0);
    check("mid_rst_resume", 32'(req_ready), 32'd1);

    // Back-to-back writes with req_valid held high.
    send_req(1'b1, 10'h000, 16'hA0A0, t0);
    send_req(1'b1, 10'h001, 16'hB1B1, t1);
    send_req(1'b1, 10'h002, 16'hC2C2, t2);
    req_valid = 1'b0;
    check("thru_gap1", 32'(t1 - t0), 32'(WRH + 1));
    check("thru_gap2", 32'(t2 - t1), 32'(WRH + 1));
    do_read(10'h002, 0, 1'b0);
    do_read(10'h000, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
